// File: rtl/beam_pkg.sv
// Shared types and default timing for the beam slot scheduler.
package beam_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Default window and guard-gap lengths in clk cycles.
    localparam int WIN_LEN_DEF = 64;
    localparam int GAP_LEN_DEF = 4;

    // One counter width serves both the window and the gap count.
    localparam int CNT_W = 9;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one pending channel, starting just after the last grant.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int LG_W   = 2
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [LG_W-1:0]   last_grant,
    output logic [NUM_CH-1:0] winner
);

    // Scan (last_grant+1) upward with wrap; the first pending channel wins.
    always_comb begin
        int         idx;
        logic       found;
        logic [LG_W-1:0] sel;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            sel = LG_W'(idx);
            if (!found && pending[sel]) begin
                winner[sel] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/beam_slot_sched.sv
// Time-slot scheduler: shares one transmit window among NUM_CH beam channels.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no window open; start one when enabled and a request is pending
// ST_ACTIVE | window open for the granted channel, cnt = cycle index
// ST_GAP    | guard gap after a window, cnt = gap cycle index, done on cycle 0
module beam_slot_sched
    import beam_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int GAP_LEN = GAP_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              enable,
    input  logic              abort,
    output logic [NUM_CH-1:0] grant,
    output logic              active,
    output logic [CNT_W-1:0]  win_cnt,
    output logic [NUM_CH-1:0] pending,
    output logic              done
);

    localparam int LG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [NUM_CH-1:0] grant_q, grant_nxt;
    logic [NUM_CH-1:0] pend_q, clr_mask, winner;
    logic [LG_W-1:0]   last_grant, lg_nxt, win_idx;
    logic              start_ok;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .LG_W   (LG_W)
    ) u_rr_arbiter (
        .pending    (pend_q),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // Uses the registered pending set, so a req in the same cycle cannot start a window.
    assign start_ok = enable && (pend_q != '0);

    // Convert the one-hot winner into an index for the round-robin pointer.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (winner[i]) begin
                win_idx = LG_W'(i);
            end
        end
    end

    // Next-state logic: window start, window end (timeout or abort), gap end.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_nxt = grant_q;
        lg_nxt    = last_grant;
        clr_mask  = '0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                    grant_nxt = winner;
                    lg_nxt    = win_idx;
                    clr_mask  = winner;
                end
            end
            ST_ACTIVE: begin
                if (abort || (cnt == CNT_W'(WIN_LEN - 1))) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                    grant_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == CNT_W'(GAP_LEN - 1)) begin
                    cnt_nxt = '0;
                    if (start_ok) begin
                        state_nxt = ST_ACTIVE;
                        grant_nxt = winner;
                        lg_nxt    = win_idx;
                        clr_mask  = winner;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                grant_nxt = '0;
            end
        endcase
    end

    // FSM state, shared counter, granted channel and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            grant_q    <= '0;
            last_grant <= LG_W'(NUM_CH - 1);
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            grant_q    <= grant_nxt;
            last_grant <= lg_nxt;
        end
    end

    // Sticky request latch; a new req beats the clear of the channel being granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_mask) | req;
        end
    end

    assign active  = (state == ST_ACTIVE);
    assign grant   = active ? grant_q : '0;
    assign win_cnt = active ? cnt : '0;
    assign done    = (state == ST_GAP) && (cnt == '0);
    assign pending = pend_q;

endmodule

// File: tb/tb_beam_slot_sched.sv
// Scoreboard bench for beam_slot_sched: expected windows are queued as requests
// are driven and checked cycle by cycle as the DUT opens and closes them.
module tb_beam_slot_sched;

    localparam int NCH = 4;
    localparam int WIN = 64;
    localparam int GAP = 4;

    typedef struct {
        logic [NCH-1:0] grant;
        int             len;
        bit             b2b;
    } win_t;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] req;
    logic           enable;
    logic           abort;
    logic [NCH-1:0] grant;
    logic           active;
    logic [8:0]     win_cnt;
    logic [NCH-1:0] pending;
    logic           done;

    int   n_chk = 0;
    int   n_err = 0;
    win_t exp_q[$];
    win_t cur;
    int   mon_st  = 0;
    int   mon_i   = 0;
    int   gap_cnt = 0;

    beam_slot_sched #(
        .NUM_CH  (NCH),
        .WIN_LEN (WIN),
        .GAP_LEN (GAP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .enable  (enable),
        .abort   (abort),
        .grant   (grant),
        .active  (active),
        .win_cnt (win_cnt),
        .pending (pending),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_win(input logic [NCH-1:0] g, input int len, input bit b2b);
        win_t w;
        w.grant = g;
        w.len   = len;
        w.b2b   = b2b;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        req    = '0;
        abort  = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(active && (win_cnt == 9'(v))) && n < 3000);
        if (!(active && (win_cnt == 9'(v)))) chk("wait_cnt", win_cnt, v);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (!(mon_st == 0 && exp_q.size() == 0 && gap_cnt > GAP + 1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("quiet_to", mon_st * 100 + exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Window monitor: pops an expected window on each start and follows it to its done cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_st  = 0;
                gap_cnt = 0;
            end else if (mon_st == 0) begin
                if (active) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_empty", exp_q.size(), 1);
                        cur.grant = '0;
                        cur.len   = WIN;
                        cur.b2b   = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    if (cur.b2b) chk("gap_len", gap_cnt, GAP);
                    chk("grant_start", grant, cur.grant);
                    chk("wcnt_start", win_cnt, 0);
                    mon_i  = 1;
                    mon_st = 1;
                end else begin
                    if (gap_cnt == 1) chk("done_once", done, 0);
                    gap_cnt++;
                end
            end else begin
                if (mon_i < cur.len) begin
                    chk("active", active, 1);
                    chk("grant", grant, cur.grant);
                    chk("win_cnt", win_cnt, mon_i);
                    mon_i++;
                end else begin
                    chk("win_end", active, 0);
                    chk("done", done, 1);
                    chk("gap_grant", grant, 0);
                    chk("gap_wcnt", win_cnt, 0);
                    mon_st  = 0;
                    gap_cnt = 1;
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        req    = '0;
        enable = 1'b1;
        abort  = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_active", active, 0);
        chk("rst_wcnt", win_cnt, 0);
        chk("rst_pending", pending, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;

        // Single request: one cycle to latch, next edge opens the window.
        @(posedge clk);
        #1 req = 4'b0100;
        push_win(4'b0100, WIN, 1'b0);
        @(posedge clk);
        #1 req = '0;
        chk("t1_pend", pending, 4'b0100);
        chk("t1_latency", active, 0);
        @(posedge clk);
        #1;
        chk("t1_grant", grant, 4'b0100);
        chk("t1_pclr", pending, 0);
        wait_quiet();
        chk("t1_idle", active, 0);

        // All channels at once: served 0,1,2,3 back to back.
        do_reset();
        @(posedge clk);
        #1 req = 4'b1111;
        push_win(4'b0001, WIN, 1'b0);
        push_win(4'b0010, WIN, 1'b1);
        push_win(4'b0100, WIN, 1'b1);
        push_win(4'b1000, WIN, 1'b1);
        @(posedge clk);
        #1 req = '0;
        wait_quiet();

        // Abort at win_cnt 10; abort held through the gap must be ignored.
        do_reset();
        @(posedge clk);
        #1 req = 4'b0101;
        push_win(4'b0001, 11, 1'b0);
        push_win(4'b0100, WIN, 1'b1);
        @(posedge clk);
        #1 req = '0;
        wait_cnt(10);
        abort = 1'b1;
        repeat (5) @(posedge clk);
        #1 abort = 1'b0;
        wait_quiet();

        // Granted channel re-requests; the other pending channel goes first.
        do_reset();
        @(posedge clk);
        #1 req = 4'b0010;
        push_win(4'b0010, WIN, 1'b0);
        @(posedge clk);
        #1 req = '0;
        wait_cnt(2);
        req = 4'b1000;
        @(posedge clk);
        #1 req = '0;
        wait_cnt(5);
        req = 4'b0010;
        @(posedge clk);
        #1 req = '0;
        chk("t4_pend", pending, 4'b1010);
        push_win(4'b1000, WIN, 1'b1);
        push_win(4'b0010, WIN, 1'b1);
        wait_quiet();

        // enable drop mid-window: full window, then idle with pending kept.
        do_reset();
        @(posedge clk);
        #1 req = 4'b0001;
        push_win(4'b0001, WIN, 1'b0);
        @(posedge clk);
        #1 req = '0;
        wait_cnt(3);
        req = 4'b0100;
        @(posedge clk);
        #1 req = '0;
        wait_cnt(20);
        enable = 1'b0;
        wait_quiet();
        repeat (5) @(posedge clk);
        #1;
        chk("t5_hold_active", active, 0);
        chk("t5_pend_kept", pending, 4'b0100);
        push_win(4'b0100, WIN, 1'b0);
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_resume", active, 1);
        wait_quiet();

        // req on the channel being granted in the same cycle keeps its pending bit.
        do_reset();
        enable = 1'b0;
        @(posedge clk);
        #1 req = 4'b0001;
        @(posedge clk);
        #1 enable = 1'b1;
        push_win(4'b0001, WIN, 1'b0);
        push_win(4'b0001, WIN, 1'b1);
        @(posedge clk);
        #1 req = '0;
        chk("t6_grant", grant, 4'b0001);
        chk("t6_setwins", pending, 4'b0001);
        wait_quiet();

        // Reset mid-window: everything clears at once, no done pulse.
        do_reset();
        @(posedge clk);
        #1 req = 4'b0001;
        push_win(4'b0001, WIN, 1'b0);
        @(posedge clk);
        #1 req = '0;
        wait_cnt(5);
        req = 4'b1000;
        @(posedge clk);
        #1 req = '0;
        wait_cnt(30);
        #2 reset = 1'b0;
        #1;
        chk("t7_grant", grant, 0);
        chk("t7_active", active, 0);
        chk("t7_wcnt", win_cnt, 0);
        chk("t7_pending", pending, 0);
        chk("t7_done", done, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk("t7_nodone", done, 0);
            chk("t7_idle", active, 0);
        end

        chk("sb_left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/beam_slot_sched.md
BEAM_SLOT_SCHED -- requirements
Module: beam_slot_sched

Interface
REQ-001 Parameter NUM_CH, default 4, number of beam channels sharing the transmit window resource.
REQ-002 Parameter WIN_LEN, default 64, active window length in cycles; legal range 1..511.
REQ-003 Parameter GAP_LEN, default 4, guard-gap length in cycles; legal range 1..511.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_CH  per-channel window request, one-cycle pulse or level.
REQ-007 enable  input  1  permits new windows to start.
REQ-008 abort  input  1  terminates the current window early.
REQ-009 grant  output  NUM_CH  one-hot granted channel, high only while a window is active.
REQ-010 active  output  1  high while a window is open.
REQ-011 win_cnt  output  9  cycle index within the current window (0..WIN_LEN-1), 0 otherwise.
REQ-012 pending  output  NUM_CH  latched, not-yet-served requests.
REQ-013 done  output  1  one-cycle pulse marking the end of a window.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACTIVE and GAP.
REQ-015 A req bit high on any edge SHALL set the matching pending bit, visible the next cycle; pending bits are sticky until served.
REQ-016 In IDLE, if enable=1 and pending!=0 at an edge, the FSM SHALL enter ACTIVE on that edge, grant the round-robin winner and clear its pending bit.
REQ-017 Round-robin SHALL search from (last_grant+1) mod NUM_CH upward with wrap-around; last_grant updates on every grant.
REQ-018 In ACTIVE: grant one-hot, active=1, win_cnt increments from 0 each cycle.
REQ-019 After WIN_LEN cycles (win_cnt=WIN_LEN-1), the FSM SHALL enter GAP.
REQ-020 abort=1 in ACTIVE SHALL enter GAP on that edge regardless of win_cnt; abort SHALL be ignored in IDLE and GAP.
REQ-021 done SHALL be high for exactly the first GAP cycle, for both normal and aborted windows.
REQ-022 GAP SHALL last exactly GAP_LEN cycles with grant=0, active=0 and win_cnt=0.
REQ-023 At GAP end: if enable=1 and pending!=0, go directly to ACTIVE with the next round-robin grant; else go to IDLE.
REQ-024 If req for the channel being granted coincides with its pending clear, set SHALL win: the bit stays 1.
REQ-025 A req from the currently granted channel during its window SHALL set pending and be served after other pending channels under round-robin.
REQ-026 enable=0 mid-window SHALL NOT shorten the window; it only blocks the next window start.
REQ-027 The window-start decision SHALL use pending as registered before the edge; a req arriving in the same cycle is not eligible until the next cycle.

Reset
REQ-028 While reset=0: state=IDLE, pending=0, grant=0, active=0, win_cnt=0, done=0, last_grant=NUM_CH-1 (channel 0 wins first).
REQ-029 Reset asserted mid-window SHALL abort immediately without a done pulse.
REQ-030 After reset releases, the first edge SHALL behave as in IDLE.

Structure
REQ-031 Shared package beam_pkg SHALL hold the state enumeration and the default WIN_LEN/GAP_LEN constants.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: pending, last_grant; output: one-hot winner).
REQ-033 Counter width SHALL be 9 bits, shared by the window and gap counts.

Verification
REQ-034 Reset release, pulse req[2] -> cycle+1 pending=0100; cycle+2 grant=0100, active=1 for 64 cycles; done at the first GAP cycle; IDLE after 4 gap cycles.
REQ-035 req=1111 held one cycle, enable=1 -> grants 0001,0010,0100,1000 in order, each 64 cycles, separated by 4-cycle gaps with no IDLE cycle between.
REQ-036 abort at win_cnt=10 on grant 0001 -> active falls next cycle; done pulses once; next pending channel is granted after 4 gap cycles.
REQ-037 Granted channel 1 re-requests at win_cnt=5 while channel 3 is pending -> channel 3 is served next, then channel 1.
REQ-038 enable=0 at win_cnt=20 -> window runs to 63; FSM goes GAP then IDLE; pending is retained; enable=1 -> next window starts.
REQ-039 reset=0 at win_cnt=30 -> all outputs 0 asynchronously; no done pulse; pending cleared.
